// File: rtl/key_sideload_seq.sv
// key_sideload_seq: snapshots a multi-share key (hw sideload or sw register file) on start and
// streams it as 32-bit words. Optional macro KEY_SIDELOAD_SEQ_WIPE_EN wipes key storage after each transfer.
module key_sideload_seq #(
    parameter int SHARES    = 2,
    parameter int KEY_WIDTH = 256,
    localparam int NUM_REGS_KEY = KEY_WIDTH / 32,
    localparam int NUM_WORDS    = SHARES * NUM_REGS_KEY,
    localparam int AW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int SHW = (SHARES > 1) ? $clog2(SHARES) : 1,
    localparam int IW  = (NUM_REGS_KEY > 1) ? $clog2(NUM_REGS_KEY) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sideload_sel_i,
    input  logic                        hw_key_valid_i,
    input  logic [SHARES*KEY_WIDTH-1:0] hw_key_i,
    input  logic                        sw_we_i,
    input  logic [AW-1:0]               sw_addr_i,
    input  logic [31:0]                 sw_wdata_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [31:0]                 out_data_o,
    output logic [SHW-1:0]              out_share_o,
    output logic [IW-1:0]               out_idx_o,
    output logic                        out_last_o,
    output logic                        done_o,
    output logic                        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [AW-1:0]  CNT_LAST = AW'(NUM_WORDS - 1);
    localparam logic [AW-1:0]  CNT_ONE  = AW'(1);
    localparam logic [IW-1:0]  IDX_MAX  = IW'(NUM_REGS_KEY - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [SHW-1:0] SHR_ONE  = SHW'(1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [31:0]   snap_r       [NUM_WORDS];
    logic [31:0]   sw_reg_r     [NUM_WORDS];
    logic [31:0]   sw_wr_word_s [NUM_WORDS];
    logic [31:0]   src_word_s   [NUM_WORDS];
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_inc_s;
    logic          addr_ok_s;
    logic          sw_wr_ok_s;
    logic          start_acc_s;
    logic          beat_s;
    logic          last_beat_s;
    logic          err_nxt_s;
    logic          wipe_s;

    assign cnt_inc_s  = cnt_r + CNT_ONE;
    assign addr_ok_s  = (32'(sw_addr_i) < 32'(NUM_WORDS));
    assign sw_wr_ok_s = sw_we_i && addr_ok_s && (state_r == ST_IDLE);

`ifdef KEY_SIDELOAD_SEQ_WIPE_EN
    assign wipe_s = (state_r == ST_DONE);
`else
    assign wipe_s = 1'b0;
`endif

    // Source selection; a same-cycle sw write is forwarded so the snapshot sees it.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (sw_wr_ok_s && (sw_addr_i == AW'(w))) begin
                sw_wr_word_s[w] = sw_wdata_i;
            end else begin
                sw_wr_word_s[w] = sw_reg_r[w];
            end
            if (sideload_sel_i) begin
                src_word_s[w] = hw_key_i[w*32 +: 32];
            end else begin
                src_word_s[w] = sw_wr_word_s[w];
            end
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        beat_s      = 1'b0;
        last_beat_s = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (sideload_sel_i && !hw_key_valid_i) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        start_acc_s = 1'b1;
                        state_nxt_s = ST_STREAM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                beat_s = out_valid_o && out_ready_i;
                if (beat_s && (cnt_r == CNT_LAST)) begin
                    last_beat_s = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
                err_nxt_s = start_i;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                err_nxt_s   = start_i;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (sw_we_i && !sw_wr_ok_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_nxt_s;
        end
    end

    // State, stream position and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= 32'h0000_0000;
            out_share_o <= '0;
            out_idx_o   <= '0;
            out_last_o  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_o  <= (state_nxt_s != ST_IDLE);
            done_o  <= (state_nxt_s == ST_DONE);
            err_o   <= err_nxt_s;
            if (start_acc_s) begin
                out_valid_o <= 1'b1;
                cnt_r       <= '0;
                out_share_o <= '0;
                out_idx_o   <= '0;
                out_data_o  <= src_word_s[0];
                out_last_o  <= (NUM_WORDS == 1) ? 1'b1 : 1'b0;
            end else if (last_beat_s) begin
                // Don't leave key material on the bus once the stream ends.
                out_valid_o <= 1'b0;
                cnt_r       <= '0;
                out_share_o <= '0;
                out_idx_o   <= '0;
                out_data_o  <= 32'h0000_0000;
                out_last_o  <= 1'b0;
            end else if (beat_s) begin
                cnt_r      <= cnt_inc_s;
                out_data_o <= snap_r[cnt_inc_s];
                out_last_o <= (cnt_inc_s == CNT_LAST);
                if (out_idx_o == IDX_MAX) begin
                    out_idx_o   <= '0;
                    out_share_o <= out_share_o + SHR_ONE;
                end else begin
                    out_idx_o   <= out_idx_o + IDX_ONE;
                end
            end else begin
                out_valid_o <= out_valid_o;
            end
        end
    end

    // Key storage: snapshot on accepted start, sw writes in IDLE, optional wipe in DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                snap_r[w]   <= 32'h0000_0000;
                sw_reg_r[w] <= 32'h0000_0000;
            end
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (start_acc_s) begin
                    snap_r[w] <= src_word_s[w];
                end else if (wipe_s) begin
                    snap_r[w] <= 32'h0000_0000;
                end else begin
                    snap_r[w] <= snap_r[w];
                end
                if (wipe_s) begin
                    sw_reg_r[w] <= 32'h0000_0000;
                end else begin
                    sw_reg_r[w] <= sw_wr_word_s[w];
                end
            end
        end
    end

endmodule

// File: tb/tb_key_sideload_seq.sv
// Self-checking bench for key_sideload_seq (SHARES=2, KEY_WIDTH=256): directed and randomized
// transfers compared against a word-list model of the key sources.
module tb_key_sideload_seq;

    localparam int NW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sideload_sel_i = 1'b0;
    logic          hw_key_valid_i = 1'b0;
    logic [511:0]  hw_key_i = '0;
    logic          sw_we_i = 1'b0;
    logic [3:0]    sw_addr_i = 4'd0;
    logic [31:0]   sw_wdata_i = 32'd0;
    logic          start_i = 1'b0;
    logic          busy_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [31:0]   out_data_o;
    logic [0:0]    out_share_o;
    logic [2:0]    out_idx_o;
    logic          out_last_o;
    logic          done_o;
    logic          err_o;

    int total  = 0;
    int passed = 0;
    logic [31:0] m_sw [NW];

    key_sideload_seq #(.SHARES(2), .KEY_WIDTH(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sideload_sel_i(sideload_sel_i),
        .hw_key_valid_i(hw_key_valid_i), .hw_key_i(hw_key_i), .sw_we_i(sw_we_i),
        .sw_addr_i(sw_addr_i), .sw_wdata_i(sw_wdata_i), .start_i(start_i),
        .busy_o(busy_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_share_o(out_share_o), .out_idx_o(out_idx_o),
        .out_last_o(out_last_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // {busy, done, valid, last, share, idx[2:0], err}
    function automatic logic [31:0] ctl_obs();
        return {23'd0, busy_o, done_o, out_valid_o, out_last_o, out_share_o, out_idx_o, err_o};
    endfunction

    task automatic randomize_hw();
        for (int k = 0; k < NW; k++) hw_key_i[k*32 +: 32] = $urandom;
    endtask

    task automatic sw_write(input logic [3:0] a, input logic [31:0] d);
        sw_we_i = 1'b1; sw_addr_i = a; sw_wdata_i = d;
        m_sw[a] = d;
        @(negedge clk_i);
        sw_we_i = 1'b0;
        check("sw_write_err", {31'd0, err_o}, 32'd0);
    endtask

    // rmode: 0 ready always, 1 stall on odd cycles, 2 random. inject: 0 none, 1 sw write, 2 start (both mid-stream).
    task automatic do_transfer(input logic sel, input int rmode, input int inject, input logic wt);
        logic [31:0] exp_w [NW];
        logic [31:0] exp_ctl;
        logic [7:0]  b8;
        logic        exp_err;
        int beats, cyc;
        sideload_sel_i = sel; hw_key_valid_i = 1'b1; start_i = 1'b1;
        if (wt) begin
            sw_we_i = 1'b1; sw_addr_i = 4'($urandom_range(15)); sw_wdata_i = $urandom;
            m_sw[sw_addr_i] = sw_wdata_i;
        end
        for (int k = 0; k < NW; k++) exp_w[k] = sel ? hw_key_i[k*32 +: 32] : m_sw[k];
        @(negedge clk_i);
        start_i = 1'b0; sw_we_i = 1'b0;
        beats = 0; cyc = 0; exp_err = 1'b0;
        while (beats < NW && cyc < 200) begin
            b8 = 8'(beats);
            check("data", out_data_o, exp_w[beats]);
            exp_ctl = {23'd0, 1'b1, 1'b0, 1'b1, (beats == NW - 1), b8[3], b8[2:0], exp_err};
            check("ctl", ctl_obs(), exp_ctl);
            exp_err = 1'b0;
            if (cyc == 4 && inject == 1) begin
                sw_we_i = 1'b1; sw_addr_i = 4'($urandom_range(15)); sw_wdata_i = $urandom;
                exp_err = 1'b1;
            end else if (cyc == 4 && inject == 2) begin
                start_i = 1'b1; exp_err = 1'b1;
            end
            case (rmode)
                0: out_ready_i = 1'b1;
                1: out_ready_i = (cyc % 2 == 0);
                default: out_ready_i = 1'($urandom_range(1));
            endcase
            randomize_hw();
            hw_key_valid_i = 1'($urandom_range(1));
            if (out_ready_i) beats++;
            @(negedge clk_i);
            start_i = 1'b0; sw_we_i = 1'b0;
            cyc++;
        end
        check("beats", 32'(beats), 32'(NW));
        if (rmode == 0) check("throughput", 32'(cyc), 32'(NW));
        check("done_cycle", {28'd0, busy_o, done_o, out_valid_o, err_o}, {28'd0, 1'b1, 1'b1, 1'b0, exp_err});
        @(negedge clk_i);
        check("after_done", {29'd0, busy_o, done_o, out_valid_o}, 32'd0);
`ifdef KEY_SIDELOAD_SEQ_WIPE_EN
        for (int k = 0; k < NW; k++) m_sw[k] = 32'd0;
`endif
    endtask

    initial begin
        for (int k = 0; k < NW; k++) m_sw[k] = 32'd0;
        #1;
        check("reset_ctl", ctl_obs(), 32'd0);
        check("reset_data", out_data_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ctl", ctl_obs(), 32'd0);

        // Patterned hw key, ready held high.
        for (int k = 0; k < 8; k++) begin
            hw_key_i[k*32 +: 32]       = 32'h1000_0000 + 32'(k);
            hw_key_i[(k+8)*32 +: 32]   = 32'h2000_0000 + 32'(k);
        end
        do_transfer(1'b1, 0, 0, 1'b0);

        // Same key with stalls on odd cycles.
        for (int k = 0; k < 8; k++) begin
            hw_key_i[k*32 +: 32]       = 32'h1000_0000 + 32'(k);
            hw_key_i[(k+8)*32 +: 32]   = 32'h2000_0000 + 32'(k);
        end
        do_transfer(1'b1, 1, 0, 1'b0);

        // Sideload selected without a valid key is rejected.
        sideload_sel_i = 1'b1; hw_key_valid_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("reject", {29'd0, err_o, out_valid_o, busy_o}, 32'b100);
        @(negedge clk_i);
        check("reject_after", {29'd0, err_o, out_valid_o, busy_o}, 32'd0);

        // Software key, hw changing mid-stream, sw write during transfer dropped.
        for (int k = 0; k < NW; k++) sw_write(4'(k), 32'hA5A5_0000 + 32'(k));
        do_transfer(1'b0, 0, 1, 1'b0);
        // Second sw transfer: repeats the words, or zeros when wiping.
        do_transfer(1'b0, 0, 2, 1'b0);

        // Reset in the middle of a transfer.
        for (int k = 0; k < NW; k++) sw_write(4'(k), $urandom);
        sideload_sel_i = 1'b0; start_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("pre_abort_idx", {29'd0, out_idx_o}, 32'd5);
        #2 rst_i = 1'b1;
        #1;
        check("abort_ctl", ctl_obs(), 32'd0);
        check("abort_data", out_data_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < NW; k++) m_sw[k] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("abort_no_done", {30'd0, done_o, busy_o}, 32'd0);
        end
        randomize_hw();
        do_transfer(1'b1, 0, 0, 1'b0);

        // Randomized transfers with write-through and mid-stream disturbances.
        for (int it = 0; it < 8; it++) begin
            randomize_hw();
            for (int j = 0; j < 4; j++) sw_write(4'($urandom_range(15)), $urandom);
            do_transfer(1'($urandom_range(1)), 2, $urandom_range(2), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
